// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared screen geometry and drawer state encodings
package graphics_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 12;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01
    } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - combinational screen clip and linear framebuffer address
module fb_addr_calc
    import graphics_pkg::*;
#(
    parameter int H_RES  = graphics_pkg::H_RES,
    parameter int V_RES  = graphics_pkg::V_RES,
    parameter int ADDR_W = graphics_pkg::ADDR_W
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               visible_o
);

    // Widen before multiplying so y*H_RES is never truncated ahead of the sum.
    assign addr_o    = ADDR_W'(y_i) * ADDR_W'(H_RES) + ADDR_W'(x_i);
    assign visible_o = (32'(x_i) < H_RES) && (32'(y_i) < V_RES);

endmodule

// File: rtl/circle_pixel_writer.sv
// rtl/circle_pixel_writer.sv - clips eight octant points and issues them as framebuffer writes
module circle_pixel_writer
    import graphics_pkg::*;
#(
    parameter int H_RES   = graphics_pkg::H_RES,
    parameter int V_RES   = graphics_pkg::V_RES,
    parameter int ADDR_W  = graphics_pkg::ADDR_W,
    parameter int COLOR_W = graphics_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [9:0]         draw_x_0,
    input  logic [9:0]         draw_x_1,
    input  logic [9:0]         draw_x_2,
    input  logic [9:0]         draw_x_3,
    input  logic [9:0]         draw_x_4,
    input  logic [9:0]         draw_x_5,
    input  logic [9:0]         draw_x_6,
    input  logic [9:0]         draw_x_7,
    input  logic [9:0]         draw_y_0,
    input  logic [9:0]         draw_y_1,
    input  logic [9:0]         draw_y_2,
    input  logic [9:0]         draw_y_3,
    input  logic [9:0]         draw_y_4,
    input  logic [9:0]         draw_y_5,
    input  logic [9:0]         draw_y_6,
    input  logic [9:0]         draw_y_7,
    input  logic [COLOR_W-1:0] color,
    input  logic               in_rts,
    output logic               in_rtr,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               out_rts,
    input  logic               out_rtr,
    output logic [15:0]        pix_count
);

    state_t                  state_q;
    logic [2:0]              idx_q;
    logic [7:0][9:0]         cap_x_q;
    logic [7:0][9:0]         cap_y_q;
    logic [COLOR_W-1:0]      cap_color_q;
    logic [15:0]             pix_count_q;

    logic [9:0]              pt_x;
    logic [9:0]              pt_y;
    logic                    pt_visible;

    assign pt_x = cap_x_q[idx_q];
    assign pt_y = cap_y_q[idx_q];

    fb_addr_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x_i       (pt_x),
        .y_i       (pt_y),
        .addr_o    (fb_addr),
        .visible_o (pt_visible)
    );

    assign in_rtr    = (state_q == ST_IDLE);
    assign out_rts   = (state_q == ST_EMIT) && pt_visible;
    assign fb_data   = cap_color_q;
    assign pix_count = pix_count_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            cap_color_q <= '0;
            pix_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_rts) begin
                        cap_x_q     <= {draw_x_7, draw_x_6, draw_x_5, draw_x_4,
                                        draw_x_3, draw_x_2, draw_x_1, draw_x_0};
                        cap_y_q     <= {draw_y_7, draw_y_6, draw_y_5, draw_y_4,
                                        draw_y_3, draw_y_2, draw_y_1, draw_y_0};
                        cap_color_q <= color;
                        idx_q       <= 3'd0;
                        state_q     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // Clipped points advance unconditionally; visible ones wait for the write.
                    if (!pt_visible || out_rtr) begin
                        if (pt_visible) begin
                            pix_count_q <= pix_count_q + 16'd1;
                        end
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circle_pixel_writer.sv
// tb/tb_circle_pixel_writer.sv - scoreboard bench for circle_pixel_writer
module tb_circle_pixel_writer;
    import graphics_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [9:0]  dx [8];
    logic [9:0]  dy [8];
    logic [11:0] color;
    logic        in_rts;
    logic        in_rtr;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    logic        out_rts;
    logic        out_rtr;
    logic [15:0] pix_count;

    always #5 clk = ~clk;

    circle_pixel_writer dut (
        .clk(clk), .rst_(rst_),
        .draw_x_0(dx[0]), .draw_x_1(dx[1]), .draw_x_2(dx[2]), .draw_x_3(dx[3]),
        .draw_x_4(dx[4]), .draw_x_5(dx[5]), .draw_x_6(dx[6]), .draw_x_7(dx[7]),
        .draw_y_0(dy[0]), .draw_y_1(dy[1]), .draw_y_2(dy[2]), .draw_y_3(dy[3]),
        .draw_y_4(dy[4]), .draw_y_5(dy[5]), .draw_y_6(dy[6]), .draw_y_7(dy[7]),
        .color(color), .in_rts(in_rts), .in_rtr(in_rtr),
        .fb_addr(fb_addr), .fb_data(fb_data), .out_rts(out_rts), .out_rtr(out_rtr),
        .pix_count(pix_count)
    );

    // Bundles: 0 centre (100,100) r=5, 1 centre (2,50) r=5, 2 corners, 3 three-visible mix.
    int bx [4][8] = '{'{105, 100, 100,   95,   95,  100,  100, 105},
                      '{  7,   2,   2, 1021, 1021,    2,    2,   7},
                      '{639, 640,   0, 1023,    0,  639,  640,   5},
                      '{ 10, 700,   0, 1000, 1000, 1000, 1000, 639}};
    int by [4][8] = '{'{100, 105, 105,  100,  100,   95,   95, 100},
                      '{ 50,  55,  55,   50,   50,   45,   45,  50},
                      '{479, 479,   0, 1023,  479,    0,    0, 480},
                      '{  0,   0,   1, 1000, 1000, 1000, 1000,   1}};
    int ea [4][8] = '{'{64105, 67300, 67300, 64095, 64095, 60900, 60900, 64105},
                      '{32007, 35202, 35202,    -1,    -1, 28802, 28802, 32007},
                      '{307199,   -1,     0,    -1, 306560,  639,    -1,    -1},
                      '{   10,    -1,   640,    -1,    -1,    -1,    -1,  1279}};
    logic [11:0] cols [4] = '{12'hABC, 12'h123, 12'hFFF, 12'h5A5};

    typedef struct packed {
        logic [18:0] a;
        logic [11:0] d;
    } wr_t;

    wr_t exp_q [$];
    wr_t exp_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  clip_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_) begin
            if (!in_rtr && !out_rts) clip_cyc++;
            if (out_rts && out_rtr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d expected no write", fb_addr);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("write_addr", int'(fb_addr), int'(exp_e.a));
                    check("write_data", int'(fb_data), int'(exp_e.d));
                end
            end
        end
    end

    task automatic send(input int b, output int t0);
        int n = 0;
        for (int i = 0; i < 8; i++)
            if (ea[b][i] >= 0) exp_q.push_back({19'(ea[b][i]), cols[b]});
        while (!in_rtr && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_rtr) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_rtr 0 expected 1");
        end
        for (int i = 0; i < 8; i++) begin
            dx[i] = 10'(bx[b][i]);
            dy[i] = 10'(by[b][i]);
        end
        color  = cols[b];
        in_rts = 1'b1;
        @(posedge clk);
        #1;
        t0     = cyc;
        in_rts = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dx[i] = 10'($urandom);
            dy[i] = 10'($urandom);
        end
        color = 12'($urandom);
    endtask

    task automatic wait_idle(input int t0, output int period);
        int n = 0;
        @(negedge clk);
        while (!in_rtr && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rtr) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got in_rtr 0 expected 1");
        end
        period = cyc - t0 + 1;
    endtask

    initial begin
        int t0;
        int p;
        in_rts  = 1'b0;
        out_rtr = 1'b1;
        color   = '0;
        for (int i = 0; i < 8; i++) begin
            dx[i] = '0;
            dy[i] = '0;
        end
        #1;
        check("reset_in_rtr", in_rtr, 1);
        check("reset_out_rts", out_rts, 0);
        check("reset_fb_addr", fb_addr, 0);
        check("reset_fb_data", fb_data, 0);
        check("reset_pix_count", pix_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;

        send(0, t0);
        check("first_req_out_rts", out_rts, 1);
        wait_idle(t0, p);
        check("bundle_period", p, 9);
        check("bundle_pix_count", pix_count, 8);
        check("bundle_drained", exp_q.size(), 0);

        send(0, t0);
        repeat (2) @(posedge clk);
        #1 out_rtr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_addr", fb_addr, 67300);
            check("stall_out_rts", out_rts, 1);
            @(posedge clk);
        end
        #1 out_rtr = 1'b1;
        wait_idle(t0, p);
        check("stall_period", p, 12);
        check("stall_pix_count", pix_count, 16);
        check("stall_drained", exp_q.size(), 0);

        clip_cyc = 0;
        send(1, t0);
        wait_idle(t0, p);
        check("clip_period", p, 9);
        check("clip_cycles", clip_cyc, 2);
        check("clip_pix_count", pix_count, 22);
        check("clip_drained", exp_q.size(), 0);

        send(0, t0);
        repeat (4) @(posedge clk);
        #1 rst_ = 1'b0;
        #1;
        check("midreset_out_rts", out_rts, 0);
        check("midreset_pix_count", pix_count, 0);
        check("midreset_fb_addr", fb_addr, 0);
        check("midreset_in_rtr", in_rtr, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        check("postreset_in_rtr", in_rtr, 1);

        send(2, t0);
        wait_idle(t0, p);
        check("corner_pix_count", pix_count, 4);
        check("corner_drained", exp_q.size(), 0);

        for (int k = 0; k < 8190; k++) begin
            send(0, t0);
            wait_idle(t0, p);
        end
        send(1, t0);
        wait_idle(t0, p);
        send(2, t0);
        wait_idle(t0, p);
        check("preload_pix_count", pix_count, 65534);

        send(3, t0);
        wait_idle(t0, p);
        check("wrap_pix_count", pix_count, 1);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
